// File: rtl/ddr_lane_dly_seq.sv
// Delay-line step sequencer: turns single LOAD/INC/DEC commands into per-lane
// DELAY_LINE_* pulses with setup, settle spacing, saturation and out-of-range abort.
module ddr_lane_dly_seq #(
    parameter int unsigned NUM_LANES     = 2,
    parameter int unsigned TAP_WIDTH     = 8,
    parameter int unsigned MAX_TAP       = 255,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned LANE_W        = 1
) (
    input  logic                           FAB_CLK,
    input  logic                           RESET,
    input  logic                           CMD_VALID,
    output logic                           CMD_READY,
    input  logic [LANE_W-1:0]              CMD_LANE,
    input  logic [1:0]                     CMD_OP,
    input  logic                           CMD_SEL,
    input  logic [TAP_WIDTH-1:0]           CMD_STEPS,
    input  logic [NUM_LANES-1:0]           OUT_OF_RANGE,
    output logic [NUM_LANES-1:0]           DELAY_LINE_SEL,
    output logic [NUM_LANES-1:0]           DELAY_LINE_LOAD,
    output logic [NUM_LANES-1:0]           DELAY_LINE_DIRECTION,
    output logic [NUM_LANES-1:0]           DELAY_LINE_MOVE,
    output logic [NUM_LANES*TAP_WIDTH-1:0] TAP_COUNT,
    output logic                           DONE,
    output logic                           ERR,
    output logic                           BUSY
);

    localparam logic [1:0] OpLoad = 2'b00;
    localparam logic [1:0] OpInc  = 2'b01;
    localparam logic [1:0] OpRsvd = 2'b11;
    localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [TAP_WIDTH-1:0] MaxTap = TAP_WIDTH'(MAX_TAP);

    typedef enum logic [2:0] {
        StIdle, StSetup, StLoad, StMove, StSettle, StFinish
    } state_e;

    state_e                               state_q, state_d;
    logic [LANE_W-1:0]                    lane_q;
    logic [1:0]                           op_q;
    logic [TAP_WIDTH-1:0]                 steps_q, steps_d;
    logic                                 err_q, err_d;
    logic [SW-1:0]                        settle_q, settle_d;
    logic [NUM_LANES-1:0][TAP_WIDTH-1:0]  tap_q;
    logic [NUM_LANES-1:0]                 sel_q, dir_q;
    logic [NUM_LANES-1:0]                 lane_hit, cmd_hit;
    logic [TAP_WIDTH-1:0]                 cur_tap;
    logic                                 accept, cmd_lane_bad, is_inc, sat, oor, move_ok;

    always_comb begin
        lane_hit = '0;
        cmd_hit  = '0;
        cur_tap  = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (lane_q == LANE_W'(i)) begin
                lane_hit[i] = 1'b1;
                cur_tap     = tap_q[i];
            end
            if (CMD_LANE == LANE_W'(i)) begin
                cmd_hit[i] = 1'b1;
            end
        end
    end

    assign accept       = CMD_VALID && (state_q == StIdle);
    assign cmd_lane_bad = 32'(CMD_LANE) >= NUM_LANES;
    assign is_inc       = (op_q == OpInc);
    // Saturation is judged before the pulse so the tap never leaves [0, MAX_TAP].
    assign sat          = is_inc ? (cur_tap == MaxTap) : (cur_tap == '0);
    assign oor          = |(OUT_OF_RANGE & lane_hit);
    assign move_ok      = (state_q == StMove) && !sat;

    always_comb begin
        state_d  = state_q;
        steps_d  = steps_q;
        err_d    = err_q;
        settle_d = settle_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    steps_d = CMD_STEPS;
                    err_d   = cmd_lane_bad;
                    state_d = cmd_lane_bad ? StFinish : StSetup;
                end
            end
            StSetup: begin
                if (op_q == OpLoad) begin
                    state_d = StLoad;
                end else if (op_q == OpRsvd || steps_q == '0) begin
                    state_d = StFinish;
                end else begin
                    state_d = StMove;
                end
            end
            StLoad: state_d = StFinish;
            StMove: begin
                if (sat) begin
                    err_d   = 1'b1;
                    state_d = StFinish;
                end else begin
                    steps_d  = steps_q - TAP_WIDTH'(1);
                    settle_d = '0;
                    state_d  = StSettle;
                end
            end
            StSettle: begin
                if (oor) begin
                    err_d   = 1'b1;
                    state_d = StFinish;
                end else if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
                    state_d = (steps_q != '0) ? StMove : StFinish;
                end else begin
                    settle_d = settle_q + SW'(1);
                end
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge FAB_CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= StIdle;
            lane_q   <= '0;
            op_q     <= '0;
            steps_q  <= '0;
            err_q    <= 1'b0;
            settle_q <= '0;
            tap_q    <= '0;
            sel_q    <= '0;
            dir_q    <= '0;
        end else begin
            state_q  <= state_d;
            steps_q  <= steps_d;
            err_q    <= err_d;
            settle_q <= settle_d;
            if (accept) begin
                lane_q <= CMD_LANE;
                op_q   <= CMD_OP;
            end
            // SEL/DIRECTION update at the accept edge so they are already valid in SETUP.
            for (int i = 0; i < NUM_LANES; i++) begin
                if (accept && cmd_hit[i]) begin
                    sel_q[i] <= CMD_SEL;
                    dir_q[i] <= (CMD_OP == OpInc);
                end
                if (lane_hit[i]) begin
                    if (state_q == StLoad) begin
                        tap_q[i] <= '0;
                    end else if (move_ok) begin
                        tap_q[i] <= is_inc ? tap_q[i] + TAP_WIDTH'(1) : tap_q[i] - TAP_WIDTH'(1);
                    end
                end
            end
        end
    end

    assign CMD_READY            = (state_q == StIdle);
    assign BUSY                 = !CMD_READY;
    assign DONE                 = (state_q == StFinish);
    assign ERR                  = (state_q == StFinish) && err_q;
    assign DELAY_LINE_SEL       = sel_q;
    assign DELAY_LINE_DIRECTION = dir_q;
    assign DELAY_LINE_LOAD      = (state_q == StLoad) ? lane_hit : '0;
    assign DELAY_LINE_MOVE      = move_ok ? lane_hit : '0;
    assign TAP_COUNT            = tap_q;

endmodule
